// File: rtl/data_cache_responder.sv
// Direct-mapped, write-back, write-allocate L1 data cache. It answers the CPU MEM-stage
// data port and moves whole 128-bit blocks to and from data memory.
//
// state         | meaning
// ST_IDLE       | serving hits; a miss leaves for write-back or fetch
// ST_WRITE_BACK | dirty victim line being written to memory
// ST_FETCH      | requested block being read from memory into the line
module data_cache_responder #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 32 - INDEX_W - 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         memRead,
    input  logic         memWrite,
    input  logic [31:0]  address,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    output logic         busywait,
    output logic         hit,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);
    localparam int NUM_SETS = 2 ** INDEX_W;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WRITE_BACK = 2'd1;
    localparam logic [1:0] ST_FETCH      = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [127:0]        data_arr [NUM_SETS];
    logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;

    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic [6:0]          word_lsb;
    logic [127:0]        line;
    logic                req;
    logic                idle_hit;
    logic                write_hit;
    logic                fetch_done;
    logic                unused_addr_bits;

    assign index            = address[INDEX_W+3:4];
    assign tag              = address[31:INDEX_W+4];
    assign word_lsb         = {address[3:2], 5'b0};
    assign unused_addr_bits = ^address[1:0];
    assign line             = data_arr[index];
    assign req              = memRead | memWrite;

    assign hit        = valid[index] && (tag_arr[index] == tag);
    assign idle_hit   = (state == ST_IDLE) && hit;
    assign busywait   = req && !idle_hit;
    // Simultaneous read and write requests are handled as a store.
    assign write_hit  = idle_hit && memWrite;
    assign fetch_done = (state == ST_FETCH) && !mem_busywait;

    assign readdata  = idle_hit ? line[word_lsb +: 32] : 32'd0;
    assign mem_read  = (state == ST_FETCH);
    assign mem_write = (state == ST_WRITE_BACK);

    always_comb begin
        mem_address   = 28'd0;
        mem_writedata = 128'd0;
        case (state)
            ST_WRITE_BACK: begin
                mem_address   = {tag_arr[index], index};
                mem_writedata = line;
            end
            ST_FETCH: mem_address = address[31:4];
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req && !hit)
                    state_nxt = (valid[index] && dirty[index]) ? ST_WRITE_BACK : ST_FETCH;
            end
            ST_WRITE_BACK: if (!mem_busywait) state_nxt = ST_FETCH;
            ST_FETCH:      if (!mem_busywait) state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_nxt;
            if (fetch_done) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end else if (write_hit) begin
                dirty[index] <= 1'b1;
            end
        end
    end

    // Arrays are not cleared; a reset during a fetch must not install a partial line.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (fetch_done) begin
                data_arr[index] <= mem_readdata;
                tag_arr[index]  <= tag;
            end else if (write_hit) begin
                data_arr[index][word_lsb +: 32] <= writedata;
            end
        end
    end
endmodule

// File: tb/tb_data_cache_responder.sv
// Scoreboard bench for data_cache_responder: directed CPU requests, a 5-busy-cycle block
// memory model, and two monitors (CPU side and memory side) popping expected responses.
module tb_data_cache_responder;
    localparam int LAT = 5;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         memRead;
    logic         memWrite;
    logic [31:0]  address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         busywait;
    logic         hit;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    data_cache_responder dut (
        .CLK(CLK), .RESET(RESET), .memRead(memRead), .memWrite(memWrite),
        .address(address), .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .hit(hit), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
    } cpu_exp_t;

    typedef struct packed {
        logic         is_write;
        logic [27:0]  addr;
        logic [127:0] data;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];
    cpu_exp_t cpu_e;
    mem_exp_t mem_e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Unwritten memory block b holds words 0xA500_0000 + byte address.
    function automatic logic [127:0] pattern(input logic [27:0] a);
        logic [31:0] b;
        b = 32'hA500_0000 + {a, 4'h0};
        return {b + 32'd12, b + 32'd8, b + 32'd4, b};
    endfunction

    logic [127:0] mem [256];
    bit   [255:0] mem_wr;
    int           mem_cnt = 0;

    assign mem_busywait = (mem_read || mem_write) && (mem_cnt != LAT);
    assign mem_readdata = mem_wr[mem_address[7:0]] ? mem[mem_address[7:0]] : pattern(mem_address);

    always @(posedge CLK) begin
        if (RESET || !(mem_read || mem_write)) begin
            mem_cnt <= 0;
        end else if (mem_cnt == LAT) begin
            mem_cnt <= 0;
            if (mem_write) begin
                mem[mem_address[7:0]]    <= mem_writedata;
                mem_wr[mem_address[7:0]] <= 1'b1;
            end
        end else begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    always @(negedge CLK) begin
        if (!RESET && (memRead || memWrite) && !busywait) begin
            if (cpu_q.size() == 0) begin
                check("cpu_unexpected_completion", {127'd0, busywait}, 128'd1);
            end else begin
                cpu_e = cpu_q.pop_front();
                check("hit_on_completion", {127'd0, hit}, 128'd1);
                if (cpu_e.is_read) check("readdata", {96'd0, readdata}, {96'd0, cpu_e.data});
            end
        end
    end

    always @(negedge CLK) begin
        if (!RESET && (mem_read || mem_write)) begin
            check("mem_rd_wr_exclusive", {127'd0, mem_read & mem_write}, 128'd0);
            if (!mem_busywait) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_transfer", {127'd0, mem_busywait}, 128'd1);
                end else begin
                    mem_e = mem_q.pop_front();
                    check("mem_write_kind", {127'd0, mem_write}, {127'd0, mem_e.is_write});
                    check("mem_address", {100'd0, mem_address}, {100'd0, mem_e.addr});
                    if (mem_e.is_write) check("mem_writedata", mem_writedata, mem_e.data);
                end
            end
        end
    end

    task automatic exp_mem(input logic w, input logic [27:0] a, input logic [127:0] d);
        mem_exp_t m;
        m = '{is_write: w, addr: a, data: d};
        mem_q.push_back(m);
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_stall,
                          input logic [31:0] exp_rdata);
        cpu_exp_t e;
        int stalls;
        e = '{is_read: rd && !wr, data: exp_rdata};
        cpu_q.push_back(e);
        memRead   = rd;
        memWrite  = wr;
        address   = addr;
        writedata = wdata;
        stalls    = 0;
        #1;
        while (busywait && stalls < 100) begin
            @(posedge CLK);
            #1;
            stalls++;
        end
        check("stall_cycles", 128'(stalls), 128'(exp_stall));
        @(posedge CLK);
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RESET     = 1'b1;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = 32'd0;
        writedata = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busywait", {127'd0, busywait}, 128'd0);
        check("rst_mem_read", {127'd0, mem_read}, 128'd0);
        check("rst_mem_write", {127'd0, mem_write}, 128'd0);
        check("rst_mem_address", {100'd0, mem_address}, 128'd0);
        check("rst_mem_writedata", mem_writedata, 128'd0);
        check("rst_readdata", {96'd0, readdata}, 128'd0);
        check("rst_hit", {127'd0, hit}, 128'd0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Clean read miss, then hits on the installed block.
        exp_mem(1'b0, 28'h1, 128'd0);
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 7, 32'hA500_0010);
        do_req(1'b0, 1'b1, 32'h14, 32'hDEAD_BEEF, 0, 32'd0);
        do_req(1'b1, 1'b0, 32'h14, 32'd0, 0, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 0, 32'hA500_0010);

        // Conflict on index 1 with the dirty line: write-back then fetch.
        exp_mem(1'b1, 28'h1, {32'hA500_001C, 32'hA500_0018, 32'hDEAD_BEEF, 32'hA500_0010});
        exp_mem(1'b0, 28'h9, 128'd0);
        do_req(1'b1, 1'b0, 32'h94, 32'd0, 13, 32'hA500_0094);

        // Line now clean: back to block 1 with no write-back; store survived in memory.
        exp_mem(1'b0, 28'h1, 128'd0);
        do_req(1'b1, 1'b0, 32'h14, 32'd0, 7, 32'hDEAD_BEEF);

        // Read and write together on a hit acts as a store and dirties the line.
        do_req(1'b1, 1'b1, 32'h18, 32'h1234_5678, 0, 32'd0);
        do_req(1'b1, 1'b0, 32'h18, 32'd0, 0, 32'h1234_5678);
        exp_mem(1'b1, 28'h1, {32'hA500_001C, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA500_0010});
        exp_mem(1'b0, 28'h9, 128'd0);
        do_req(1'b1, 1'b0, 32'h98, 32'd0, 13, 32'hA500_0098);

        // Write miss allocates the line before storing.
        exp_mem(1'b0, 28'h3, 128'd0);
        do_req(1'b0, 1'b1, 32'h3C, 32'hCAFE_F00D, 7, 32'd0);
        do_req(1'b1, 1'b0, 32'h3C, 32'd0, 0, 32'hCAFE_F00D);
        do_req(1'b1, 1'b0, 32'h30, 32'd0, 0, 32'hA500_0030);

        // Reset in the middle of a fetch.
        memRead = 1'b1;
        address = 32'h200;
        repeat (3) @(posedge CLK);
        #1;
        check("fetch_mem_read", {127'd0, mem_read}, 128'd1);
        check("fetch_mem_address", {100'd0, mem_address}, 128'h20);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        address = 32'h98;
        #1;
        check("rst_mid_mem_read", {127'd0, mem_read}, 128'd0);
        check("rst_mid_mem_write", {127'd0, mem_write}, 128'd0);
        check("rst_mid_hit_cleared", {127'd0, hit}, 128'd0);
        memRead = 1'b0;
        RESET   = 1'b0;
        @(posedge CLK);
        #1;

        exp_mem(1'b0, 28'h1, 128'd0);
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 7, 32'hA500_0010);
        do_req(1'b1, 1'b0, 32'h18, 32'd0, 0, 32'h1234_5678);

        repeat (3) @(posedge CLK);
        #1;
        check("cpu_queue_drained", 128'(cpu_q.size()), 128'd0);
        check("mem_queue_drained", 128'(mem_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
